// File: rtl/piezo_sound_if.sv
// Request/playback bundle between the sound sources and the piezo arbiter.
interface piezo_sound_if;
    logic [3:0]  req;
    logic [1:0]  item_sel;
    logic [11:0] tone_period;
    logic [3:0]  grant;
    logic        busy;
    logic        done;

    modport master (output req, item_sel, input tone_period, grant, busy, done);
    modport slave  (input req, item_sel, output tone_period, grant, busy, done);
endinterface

// File: rtl/piezo_sound_arbiter.sv
// Arbitrates four sound requests onto one piezo tone generator and plays
// four fixed-length note slots per sound.
//
// state | meaning
// IDLE  | nothing playing; grant highest pending request
// PLAY  | stepping through the 4 note slots of the granted sound
// DONE  | one silent cycle with done pulse before returning to IDLE
module piezo_sound_arbiter #(
    parameter int NOTE_TICKS = 100000
) (
    input  logic          clk,
    input  logic          rst,
    piezo_sound_if.slave  bus
);
    localparam int TICK_W = $clog2(NOTE_TICKS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(NOTE_TICKS - 1);

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        pending;
    logic [1:0]        item_q;
    logic [1:0]        play_item;
    logic [1:0]        snd;
    logic [1:0]        slot;
    logic [TICK_W-1:0] tick;
    logic [11:0]       tone;
    logic [3:0]        grant_q;

    logic [3:0]        set_mask;
    logic [3:0]        clr_mask;
    logic [1:0]        win;
    logic              start;
    logic              tick_end;

    function automatic logic [11:0] note(input logic [1:0] s, input logic [1:0] sel,
                                         input logic [1:0] sl);
        logic [11:0] n;
        n = 12'd0;
        case (s)
            2'd0: begin
                case (sel)
                    2'd1:    n = 12'd3830;
                    2'd2:    n = 12'd2550;
                    2'd3:    n = 12'd2028;
                    default: n = 12'd0;
                endcase
                if (sl[0]) n = 12'd0;
            end
            2'd1: begin
                case (sl)
                    2'd0:    n = 12'd3830;
                    2'd1:    n = 12'd3038;
                    default: n = 12'd2550;
                endcase
            end
            2'd2: begin
                case (sl)
                    2'd0:    n = 12'd2550;
                    2'd1:    n = 12'd3038;
                    2'd2:    n = 12'd3830;
                    default: n = 12'd0;
                endcase
            end
            default: n = sl[0] ? 12'd0 : 12'd1912;
        endcase
        return n;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        clr_mask  = 4'b0000;
        set_mask  = bus.req;
        if (bus.item_sel == 2'd0) set_mask[0] = 1'b0;
        tick_end  = (tick == TICK_LAST);
        if      (pending[3]) win = 2'd3;
        else if (pending[2]) win = 2'd2;
        else if (pending[1]) win = 2'd1;
        else                 win = 2'd0;
        case (state)
            IDLE: begin
                if (pending != 4'b0000) begin
                    start     = 1'b1;
                    clr_mask  = 4'b0001 << win;
                    state_nxt = PLAY;
                end
            end
            PLAY:    if (tick_end && slot == 2'd3) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A request landing on its own grant edge survives the clear (set wins).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= 4'b0000;
            item_q    <= 2'd0;
            play_item <= 2'd0;
            snd       <= 2'd0;
            slot      <= 2'd0;
            tick      <= '0;
            tone      <= 12'd0;
            grant_q   <= 4'b0000;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
            if (set_mask[0]) item_q <= bus.item_sel;
            if (start) begin
                snd       <= win;
                play_item <= item_q;
                slot      <= 2'd0;
                tick      <= '0;
                grant_q   <= 4'b0001 << win;
                tone      <= note(win, item_q, 2'd0);
            end else if (state == PLAY) begin
                if (tick_end) begin
                    tick <= '0;
                    if (slot == 2'd3) begin
                        tone    <= 12'd0;
                        grant_q <= 4'b0000;
                    end else begin
                        slot <= slot + 2'd1;
                        tone <= note(snd, play_item, slot + 2'd1);
                    end
                end else begin
                    tick <= tick + 1'b1;
                end
            end
        end
    end

    assign bus.tone_period = tone;
    assign bus.grant       = grant_q;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
endmodule

// File: tb/tb_piezo_sound_arbiter.sv
// Randomized bench for piezo_sound_arbiter against a sequence-level reference model.
`timescale 1ns/1ps
module tb_piezo_sound_arbiter;
    localparam int NT = 4;
    localparam int SEQ_LEN = 4 * NT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    piezo_sound_if bus();

    piezo_sound_arbiter #(.NOTE_TICKS(NT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_done = 0;

    // Model: m_phase = cycles since grant (-1 idle, SEQ_LEN = done cycle).
    int         m_phase = -1;
    logic [3:0] m_pend  = 4'b0000;
    int         m_item  = 0;
    int         m_snd   = 0;
    int         m_play_item = 0;

    int item_note [4] = '{0, 3830, 2550, 2028};
    int coin_tbl  [4] = '{3830, 3038, 2550, 2550};
    int chg_tbl   [4] = '{2550, 3038, 3830, 0};
    int err_tbl   [4] = '{1912, 0, 1912, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    function automatic int exp_tone(input int s, input int item, input int sl);
        case (s)
            0:       return (sl % 2 == 0) ? item_note[item] : 0;
            1:       return coin_tbl[sl];
            2:       return chg_tbl[sl];
            default: return err_tbl[sl];
        endcase
    endfunction

    task automatic model_reset();
        m_phase = -1;
        m_pend  = 4'b0000;
        m_item  = 0;
        m_snd   = 0;
        m_play_item = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic [1:0] sel);
        logic [3:0] setm;
        int w;
        setm = r;
        if (sel == 2'd0) setm[0] = 1'b0;
        if (m_phase == SEQ_LEN) begin
            m_phase = -1;
        end else if (m_phase >= 0) begin
            m_phase++;
        end else if (m_pend != 4'b0000) begin
            w = 0;
            for (int i = 0; i < 4; i++) if (m_pend[i]) w = i;
            m_snd = w;
            m_pend[w] = 1'b0;
            m_play_item = m_item;
            m_phase = 0;
        end
        m_pend = m_pend | setm;
        if (setm[0]) m_item = int'(sel);
    endtask

    always @(posedge clk or posedge rst) begin
        int e_tone, e_grant, e_busy, e_done;
        #1;
        if (rst) model_reset();
        else     model_step(bus.req, bus.item_sel);
        e_tone = 0; e_grant = 0; e_busy = 0; e_done = 0;
        if (m_phase >= 0 && m_phase < SEQ_LEN) begin
            e_tone  = exp_tone(m_snd, m_play_item, m_phase / NT);
            e_grant = 1 << m_snd;
            e_busy  = 1;
        end else if (m_phase == SEQ_LEN) begin
            e_busy = 1;
            e_done = 1;
        end
        chk("tone_period", 32'(bus.tone_period), 32'(e_tone));
        chk("grant",       32'(bus.grant),       32'(e_grant));
        chk("busy",        32'(bus.busy),        32'(e_busy));
        chk("done",        32'(bus.done),        32'(e_done));
        if (bus.done === 1'b1 && !rst) n_done++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [3:0] r, input logic [1:0] s);
        @(negedge clk);
        bus.req = r;
        bus.item_sel = s;
        @(negedge clk);
        bus.req = 4'b0000;
        bus.item_sel = 2'($urandom);
    endtask

    initial begin
        int d0;
        logic [3:0] r;
        bus.req = 4'b0000;
        bus.item_sel = 2'd0;
        idle(3);
        rst = 1'b0;
        idle(3);

        // coin sequence
        d0 = n_done;
        pulse(4'b0010, 2'd0);
        idle(22);
        chk("coin_done_count", 32'(n_done - d0), 32'd1);

        // simultaneous error + item(sel 2)
        d0 = n_done;
        pulse(4'b1001, 2'd2);
        idle(42);
        chk("simul_done_count", 32'(n_done - d0), 32'd2);

        // no preemption: item playing, error arrives in slot 1
        pulse(4'b0001, 2'd1);
        idle(4);
        pulse(4'b1000, 2'd0);
        idle(40);

        // item_sel=0 ignored
        d0 = n_done;
        pulse(4'b0001, 2'd0);
        idle(6);
        chk("sel0_busy", 32'(bus.busy), 32'd0);
        chk("sel0_done_count", 32'(n_done - d0), 32'd0);

        // change pulsed 3 times while pending behind a coin
        d0 = n_done;
        pulse(4'b0010, 2'd0);
        idle(2);
        pulse(4'b0100, 2'd0);
        pulse(4'b0100, 2'd0);
        pulse(4'b0100, 2'd0);
        idle(45);
        chk("change_once_count", 32'(n_done - d0), 32'd2);

        // change re-pulsed during its own play
        d0 = n_done;
        pulse(4'b0100, 2'd0);
        idle(6);
        pulse(4'b0100, 2'd0);
        idle(45);
        chk("change_replay_count", 32'(n_done - d0), 32'd2);

        // reset mid-PLAY of coin; requests during reset discarded
        pulse(4'b0010, 2'd0);
        idle(7);
        #2;
        rst = 1'b1;
        bus.req = 4'b1111;
        bus.item_sel = 2'd1;
        #1;
        chk("rst_async_tone",  32'(bus.tone_period), 32'd0);
        chk("rst_async_grant", 32'(bus.grant),       32'd0);
        chk("rst_async_busy",  32'(bus.busy),        32'd0);
        d0 = n_done;
        idle(3);
        bus.req = 4'b0000;
        rst = 1'b0;
        idle(25);
        chk("rst_no_done", 32'(n_done - d0), 32'd0);
        chk("rst_stays_idle", 32'(bus.busy), 32'd0);
        pulse(4'b0010, 2'd0);
        idle(20);

        // randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                bus.req = 4'($urandom);
                idle(2);
                rst = 1'b0;
            end
            r = 4'b0000;
            for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 19) == 0);
            bus.req = r;
            bus.item_sel = 2'($urandom);
        end
        @(negedge clk);
        bus.req = 4'b0000;
        idle(90);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
